// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - capture FSM state type and ring pointer helpers
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMING  = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } cap_state_t;

  // Ring depth need not be a power of two, so wrap by compare rather than masking.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a == depth - 32'd1) ? 32'd0 : a + 32'd1;
  endfunction

  function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
    return (a >= b) ? a - b : a + depth - b;
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - sample input and window output streams of capture_sequencer
interface capture_sequencer_if #(
  parameter int DWIDTH = 14
);
  logic [DWIDTH-1:0] SAMPLE_IN;
  logic              SAMPLE_VALID;
  logic [DWIDTH-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;

  modport master (
    output SAMPLE_IN, SAMPLE_VALID, OUT_READY,
    input  OUT_DATA, OUT_VALID, OUT_LAST
  );

  modport slave (
    input  SAMPLE_IN, SAMPLE_VALID, OUT_READY,
    output OUT_DATA, OUT_VALID, OUT_LAST
  );
endinterface

// File: rtl/capture_sequencer_ring.sv
// rtl/capture_sequencer_ring.sv - simple dual-port sample RAM, sync write, registered read
module capture_sequencer_ring #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 14
) (
  input  logic          CLOCK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - threshold trigger, pre/post window freeze and oldest-first readout
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int MAX_SAMPLES = 16,
  parameter int ADDR_BITS   = $clog2(MAX_SAMPLES),
  parameter int DWIDTH      = 14,
  parameter int PRE_SAMPLES = 4,
  parameter int CNT_BITS    = 16
) (
  input  logic                CLOCK,
  input  logic                RESET,
  capture_sequencer_if.slave  bus,
  input  logic [DWIDTH-1:0]   THRESHOLD,
  input  logic                ARM,
  input  logic                AUTO_REARM,
  output logic                DONE,
  output logic                BUSY,
  output logic [CNT_BITS-1:0] TRIG_COUNT,
  output logic [CNT_BITS-1:0] MISSED_COUNT
);
  localparam int POST_LEN = MAX_SAMPLES - PRE_SAMPLES;
  localparam int RD_CNT_W = ADDR_BITS + 1;

  cap_state_t state, state_nxt;

  logic [ADDR_BITS-1:0] wr_addr, trig_addr, rd_ptr, pre_cnt, post_cnt;
  logic [RD_CNT_W-1:0]  rd_cnt;
  logic [DWIDTH-1:0]    prev, ring_rdata, out_data;
  logic rd_pending, pending_last, out_valid, out_last;
  logic crossing, accept, last_acc, pre_full, post_full, rd_left;
  logic wr_en, rd_en, trigger, freeze, missed;

  assign crossing  = bus.SAMPLE_VALID && (bus.SAMPLE_IN >= THRESHOLD) && (prev < THRESHOLD);
  assign accept    = out_valid && bus.OUT_READY;
  assign last_acc  = accept && out_last;
  assign pre_full  = bus.SAMPLE_VALID && (pre_cnt == ADDR_BITS'(PRE_SAMPLES - 1));
  assign post_full = (post_cnt == ADDR_BITS'(POST_LEN));
  assign rd_left   = (rd_cnt != RD_CNT_W'(MAX_SAMPLES));

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ARM) state_nxt = ARMING;
      ARMING:  if (!ARM) state_nxt = IDLE;
               else if (pre_full) state_nxt = ARMED;
      ARMED:   if (!ARM) state_nxt = IDLE;
               else if (crossing) state_nxt = POST;
      POST:    if (post_full) state_nxt = READOUT;
      READOUT: if (last_acc) state_nxt = (AUTO_REARM && ARM) ? ARMING : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A read issues only into an empty (or emptying) output register with nothing in flight.
  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    trigger = 1'b0;
    freeze  = 1'b0;
    missed  = 1'b0;
    case (state)
      ARMING: wr_en = bus.SAMPLE_VALID;
      ARMED: begin
        wr_en   = bus.SAMPLE_VALID;
        trigger = ARM && crossing;
      end
      POST: begin
        wr_en  = bus.SAMPLE_VALID && !post_full;
        freeze = post_full;
        missed = ARM && crossing;
      end
      READOUT: begin
        rd_en  = rd_left && !rd_pending && (!out_valid || accept);
        missed = ARM && crossing;
      end
      default: ;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_addr      <= '0;
      trig_addr    <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      prev         <= '0;
      TRIG_COUNT   <= '0;
      MISSED_COUNT <= '0;
    end else begin
      if (freeze)                prev <= '0;
      else if (bus.SAMPLE_VALID) prev <= bus.SAMPLE_IN;
      if (wr_en) wr_addr <= ADDR_BITS'(wrap_inc(32'(wr_addr), 32'(MAX_SAMPLES)));
      if (state != ARMING)         pre_cnt <= '0;
      else if (bus.SAMPLE_VALID)   pre_cnt <= pre_cnt + 1'b1;
      if (trigger)                        post_cnt <= ADDR_BITS'(1);
      else if (wr_en && state == POST)    post_cnt <= post_cnt + 1'b1;
      if (trigger) trig_addr <= wr_addr;
      if (trigger && TRIG_COUNT != '1)  TRIG_COUNT   <= TRIG_COUNT + 1'b1;
      if (missed && MISSED_COUNT != '1) MISSED_COUNT <= MISSED_COUNT + 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr       <= '0;
      rd_cnt       <= '0;
      rd_pending   <= 1'b0;
      pending_last <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      DONE         <= 1'b0;
    end else begin
      DONE       <= last_acc;
      rd_pending <= rd_en;
      if (freeze) begin
        rd_ptr <= ADDR_BITS'(wrap_sub(32'(trig_addr), 32'(PRE_SAMPLES), 32'(MAX_SAMPLES)));
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_ptr       <= ADDR_BITS'(wrap_inc(32'(rd_ptr), 32'(MAX_SAMPLES)));
        rd_cnt       <= rd_cnt + 1'b1;
        pending_last <= (rd_cnt == RD_CNT_W'(MAX_SAMPLES - 1));
      end
      if (rd_pending) begin
        out_data  <= ring_rdata;
        out_valid <= 1'b1;
        out_last  <= pending_last;
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign bus.OUT_DATA  = out_data;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_LAST  = out_last;

  capture_sequencer_ring #(
    .DEPTH (MAX_SAMPLES),
    .AW    (ADDR_BITS),
    .DW    (DWIDTH)
  ) u_ring (
    .CLOCK   (CLOCK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.SAMPLE_IN),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ring_rdata)
  );
endmodule
